// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner encodings for the memory port arbiter
package mem_arb_pkg;
    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_BUSY_IF  = 2'd1;
    localparam logic [1:0] ARB_BUSY_MEM = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = ARB_IDLE,
        ST_BUSY_IF  = ARB_BUSY_IF,
        ST_BUSY_MEM = ARB_BUSY_MEM
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts BUSY cycles and flags the cycle on which the access must be aborted
//  clk, reset : clock, synchronous active-high reset
//  clr        : clear the count (held while the arbiter is idle)
//  en         : count this cycle (arbiter busy)
//  expire     : this is the TIMEOUT-th busy cycle
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end

    assign expire = en && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
//  if_req/if_addr               : IF read request; if_gnt/if_rvalid/if_rerr pulses back
//  mem_req/mem_we/mem_addr/wdata: MEM request; mem_gnt/mem_rvalid/mem_rerr pulses back
//  rdata                        : registered read data for whichever owner completes
//  bus_req/we/addr/wdata        : latched access toward the bus; bus_ready/bus_rdata back
//  struct_hazard                : combinational, IF is blocked by MEM ownership
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic              if_rerr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic              mem_rerr,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              struct_hazard
);
    localparam int SW = $clog2(MAX_WAIT + 1);

    arb_state_t    state, state_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    owner_t        owner;
    logic          idle, busy, mem_sel, if_sel, expire, done;

    assign idle    = state == ST_IDLE;
    assign busy    = !idle;
    assign owner   = state == ST_BUSY_MEM ? OWN_MEM : OWN_IF;
    // MEM normally has priority; a starved IF gets exactly one win
    assign mem_sel = mem_req && !(if_req && starve_cnt == SW'(MAX_WAIT));
    assign if_sel  = if_req && !mem_sel;
    // bus_ready beats a coincident timeout
    assign done    = busy && (bus_ready || expire);

    assign struct_hazard = if_req && (state == ST_BUSY_MEM || (idle && mem_sel));

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clr    (idle),
        .en     (busy),
        .expire (expire)
    );

    always_comb begin
        state_nx  = idle ? (mem_sel ? ST_BUSY_MEM : if_sel ? ST_BUSY_IF : ST_IDLE)
                         : (done ? ST_IDLE : state);
        starve_nx = !idle ? starve_cnt
                  : if_sel ? '0
                  : (if_req && mem_sel && starve_cnt != SW'(MAX_WAIT)) ? starve_cnt + SW'(1)
                  : starve_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rerr    <= 1'b0;
            mem_gnt    <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_rerr   <= 1'b0;
            rdata      <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            if_gnt     <= idle && if_sel;
            mem_gnt    <= idle && mem_sel;
            if_rvalid  <= done && owner == OWN_IF;
            mem_rvalid <= done && owner == OWN_MEM;
            if_rerr    <= done && !bus_ready && owner == OWN_IF;
            mem_rerr   <= done && !bus_ready && owner == OWN_MEM;
            if (done) rdata <= (bus_ready && !bus_we) ? bus_rdata : '0;
            if (idle && (if_sel || mem_sel)) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_sel && mem_we;
                bus_addr  <= mem_sel ? mem_addr : if_addr;
                bus_wdata <= mem_sel ? mem_wdata : '0;
            end else if (done) begin
                bus_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, mem_req, mem_we, bus_ready;
    logic [AW-1:0] if_addr, mem_addr;
    logic [DW-1:0] mem_wdata, bus_rdata;
    logic          if_gnt, if_rvalid, if_rerr, mem_gnt, mem_rvalid, mem_rerr;
    logic [DW-1:0] rdata, bus_wdata;
    logic          bus_req, bus_we, struct_hazard;
    logic [AW-1:0] bus_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rerr(if_rerr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rerr(mem_rerr),
        .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .struct_hazard(struct_hazard)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Transaction-level model: one outstanding access, its owner, its age, and the IF loss count
    bit            m_busy, m_mem;
    int            m_age, m_starve;
    logic          e_if_gnt, e_if_rvalid, e_if_rerr, e_mem_gnt, e_mem_rvalid, e_mem_rerr;
    logic          e_bus_req, e_bus_we;
    logic [DW-1:0] e_rdata, e_bus_wdata;
    logic [AW-1:0] e_bus_addr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [103:0] outs();
        return {if_gnt, if_rvalid, if_rerr, mem_gnt, mem_rvalid, mem_rerr,
                rdata, bus_req, bus_we, bus_addr, bus_wdata};
    endfunction

    function automatic logic [103:0] exp_outs();
        return {e_if_gnt, e_if_rvalid, e_if_rerr, e_mem_gnt, e_mem_rvalid, e_mem_rerr,
                e_rdata, e_bus_req, e_bus_we, e_bus_addr, e_bus_wdata};
    endfunction

    function automatic logic exp_haz();
        return if_req && (m_busy ? m_mem : (mem_req && m_starve != MW));
    endfunction

    task automatic model_step();
        bit iw, mw;
        {e_if_gnt, e_if_rvalid, e_if_rerr, e_mem_gnt, e_mem_rvalid, e_mem_rerr} = '0;
        if (reset) begin
            m_busy = 0; m_starve = 0; m_age = 0;
            e_rdata = '0; e_bus_req = 0; e_bus_we = 0; e_bus_addr = '0; e_bus_wdata = '0;
        end else if (!m_busy) begin
            iw = if_req && (!mem_req || m_starve == MW);
            mw = mem_req && !iw;
            if (iw || mw) begin
                m_busy = 1; m_mem = mw; m_age = 0;
                e_bus_req = 1; e_bus_we = mw && mem_we;
                e_bus_addr = mw ? mem_addr : if_addr;
                e_bus_wdata = mw ? mem_wdata : '0;
                e_if_gnt = iw; e_mem_gnt = mw;
            end
            if (iw) m_starve = 0;
            else if (mw && if_req && m_starve < MW) m_starve++;
        end else begin
            m_age++;
            if (bus_ready || m_age == TO) begin
                m_busy = 0; e_bus_req = 0;
                e_rdata = (bus_ready && !e_bus_we) ? bus_rdata : '0;
                e_if_rvalid = !m_mem; e_mem_rvalid = m_mem;
                e_if_rerr = !m_mem && !bus_ready; e_mem_rerr = m_mem && !bus_ready;
            end
        end
    endtask

    task automatic tick();
        #1;
        chk("hazard", struct_hazard, exp_haz());
        model_step();
        @(posedge clk);
        #1;
        chk("outs", outs(), exp_outs());
    endtask

    initial begin
        int nmem, ngnt, nrv;
        bit got_if;
        reset = 1; if_req = 0; mem_req = 0; mem_we = 0; bus_ready = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
        m_busy = 0; m_mem = 0; m_age = 0; m_starve = 0;
        tick(); tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_rdata", rdata, 0);
        reset = 0;
        tick();

        // 1: lone IF read, bus_ready two cycles after bus_req
        if_req = 1; if_addr = 32'h100; bus_rdata = 32'hCAFE_F00D;
        tick();
        chk("t1_gnt", {if_gnt, bus_req, bus_addr}, {2'b11, 32'h100});
        if_req = 0;
        tick(); tick();
        chk("t1_haz", struct_hazard, 0);
        bus_ready = 1;
        tick();
        chk("t1_rvalid", {if_rvalid, if_rerr, rdata}, {2'b10, 32'hCAFE_F00D});
        bus_ready = 0;
        tick();

        // 2: IF and MEM collide, MEM write wins, IF follows
        if_req = 1; mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'h1234_5678;
        #1 chk("t2_haz_idle", struct_hazard, 1);
        tick();
        chk("t2_gnt", {mem_gnt, if_gnt, bus_we, bus_wdata}, {3'b101, 32'h1234_5678});
        mem_req = 0;
        tick();
        chk("t2_haz_busy", struct_hazard, 1);
        bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        chk("t2_wack", {mem_rvalid, mem_rerr, rdata}, {2'b10, 32'h0});
        bus_ready = 0;
        tick();
        chk("t2_if_next", {if_gnt, bus_we}, 2'b10);
        if_req = 0; bus_ready = 1;
        tick();
        bus_ready = 0;
        tick();

        // 3: MEM held high, IF starves for MAX_WAIT losses then wins once
        mem_req = 1; mem_we = 0; if_req = 1; bus_ready = 1;
        nmem = 0; got_if = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_gnt && !got_if) begin
                got_if = 1;
                chk("t3_losses", nmem, MW);
                chk("t3_starve_clr", dut.starve_cnt, 0);
            end
            if (mem_gnt && !got_if) nmem++;
        end
        chk("t3_if_won", got_if, 1);
        mem_req = 0; if_req = 0;
        tick(); tick();
        bus_ready = 0;
        tick();

        // 4: hung bus times out after TIMEOUT busy cycles; a ready on the last cycle wins
        mem_req = 1; mem_we = 0;
        tick();
        chk("t4_gnt", mem_gnt, 1);
        mem_req = 0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk("t4_wait", {mem_rvalid, mem_rerr}, k == TO ? 2'b11 : 2'b00);
        end
        chk("t4_idle", dut.state, ARB_IDLE);
        mem_req = 1;
        tick();
        mem_req = 0;
        for (int k = 1; k < TO; k++) tick();
        bus_ready = 1; bus_rdata = 32'h0BAD_CAFE;
        tick();
        chk("t4_ready_last", {mem_rvalid, mem_rerr, rdata}, {2'b10, 32'h0BAD_CAFE});
        bus_ready = 0;
        tick();

        // 5: reset in the second BUSY_MEM cycle
        mem_req = 1;
        tick();
        mem_req = 0;
        tick();
        reset = 1;
        tick();
        chk("t5_abort", {bus_req, mem_rvalid}, 2'b00);
        chk("t5_state", dut.state, ARB_IDLE);
        reset = 0;
        tick();
        if_req = 1; if_addr = 32'h400;
        tick();
        chk("t5_if_gnt", {if_gnt, bus_addr}, {1'b1, 32'h400});
        if_req = 0; bus_ready = 1;
        tick();
        bus_ready = 0;
        tick();

        // 6: random stress
        ngnt = 0; nrv = 0;
        for (int i = 0; i < 10000; i++) begin
            if_req = 1'($urandom_range(0, 1));
            mem_req = 1'($urandom_range(0, 1));
            mem_we = 1'($urandom_range(0, 1));
            if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom; bus_rdata = $urandom;
            bus_ready = $urandom_range(0, 9) < 3;
            tick();
            if (if_gnt && mem_gnt) chk("t6_onehot_gnt", {if_gnt, mem_gnt}, 2'b01);
            if (if_rvalid && mem_rvalid) chk("t6_onehot_rv", {if_rvalid, mem_rvalid}, 2'b01);
            ngnt += int'(if_gnt) + int'(mem_gnt);
            nrv += int'(if_rvalid) + int'(mem_rvalid);
        end
        if_req = 0; mem_req = 0; bus_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nrv += int'(if_rvalid) + int'(mem_rvalid);
        end
        chk("t6_rv_per_gnt", nrv, ngnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
